// File: rtl/lcd_wr_sched.sv
// lcd_wr_sched: round-robin two-requester scheduler driving an 8080-style LCD write cycle
module lcd_wr_sched #(
  parameter int DW      = 24,
  parameter int T_SETUP = 2,
  parameter int T_LOW   = 3,
  parameter int T_HOLD  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic          a_rs,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic          b_rs,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          busy,
  output logic          lcd_cs,
  output logic          lcd_rs,
  output logic          lcd_wr,
  output logic          lcd_rd,
  output logic [DW-1:0] lcd_data
);
  localparam logic [7:0] C_SETUP = (T_SETUP < 2) ? 8'd0 : 8'(T_SETUP - 1);
  localparam logic [7:0] C_LOW   = (T_LOW   < 2) ? 8'd0 : 8'(T_LOW   - 1);
  localparam logic [7:0] C_HOLD  = (T_HOLD  < 2) ? 8'd0 : 8'(T_HOLD  - 1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_last_b;
  logic       w_idle, w_grant_b, w_any, w_done;
  always_comb begin
    w_idle    = r_state == IDLE;
    w_grant_b = b_valid & (~a_valid | ~r_last_b);
    w_any     = a_valid | b_valid;
    w_done    = r_cnt == 8'd0;
    a_ready   = w_idle & rst & a_valid & ~w_grant_b;
    b_ready   = w_idle & rst & w_grant_b;
  end
  always_ff @(posedge clk) begin
    lcd_rd <= 1'b1;
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_last_b <= 1'b1;
      lcd_cs   <= 1'b1;
      lcd_wr   <= 1'b1;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_state  <= SETUP;
          r_cnt    <= C_SETUP;
          r_last_b <= w_grant_b;
          lcd_rs   <= w_grant_b ? b_rs : a_rs;
          lcd_data <= w_grant_b ? b_data : a_data;
          lcd_cs   <= 1'b0;
          busy     <= 1'b1;
        end
        SETUP: if (w_done) begin
          r_state <= STROBE;
          r_cnt   <= C_LOW;
          lcd_wr  <= 1'b0;
        end else r_cnt <= r_cnt - 8'd1;
        STROBE: if (w_done) begin
          r_state <= HOLD;
          r_cnt   <= C_HOLD;
          lcd_wr  <= 1'b1;
        end else r_cnt <= r_cnt - 8'd1;
        HOLD: if (w_done) begin
          r_state <= IDLE;
          lcd_cs  <= 1'b1;
          busy    <= 1'b0;
        end else r_cnt <= r_cnt - 8'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_wr_sched.sv
// tb_lcd_wr_sched: directed and random checks of two parameterisations against a cycle-offset model
module tb_lcd_wr_sched;
  logic clk = 1'b0;
  logic rst, a_valid, a_rs, b_valid, b_rs;
  logic [23:0] a_data, b_data;
  logic [1:0] a_ready, b_ready, busy, cs, rs, wr, rd;
  logic [23:0] dout [2];
  int total = 0, bad = 0;
  int cs_low [2], wr_low [2];
  int ts [2] = '{2, 1};
  int tl [2] = '{3, 1};
  int th [2] = '{3, 1};
  int m_t [2];
  bit m_lb [2], m_rs [2];
  logic [23:0] m_d [2];

  always #5 clk = ~clk;

  lcd_wr_sched u0 (.clk(clk), .rst(rst), .a_valid(a_valid), .a_rs(a_rs), .a_data(a_data),
    .a_ready(a_ready[0]), .b_valid(b_valid), .b_rs(b_rs), .b_data(b_data), .b_ready(b_ready[0]),
    .busy(busy[0]), .lcd_cs(cs[0]), .lcd_rs(rs[0]), .lcd_wr(wr[0]), .lcd_rd(rd[0]), .lcd_data(dout[0]));
  lcd_wr_sched #(.DW(24), .T_SETUP(0), .T_LOW(1), .T_HOLD(1)) u1 (.clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rs(a_rs), .a_data(a_data), .a_ready(a_ready[1]), .b_valid(b_valid),
    .b_rs(b_rs), .b_data(b_data), .b_ready(b_ready[1]), .busy(busy[1]), .lcd_cs(cs[1]),
    .lcd_rs(rs[1]), .lcd_wr(wr[1]), .lcd_rd(rd[1]), .lcd_data(dout[1]));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] grant(int i);
    bit idle = m_t[i] < 0;
    grant[0] = idle && rst && a_valid && (!b_valid || m_lb[i]);
    grant[1] = idle && rst && b_valid && (!a_valid || !m_lb[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = -1; m_lb[i] = 1'b1; m_rs[i] = 1'b0; m_d[i] = '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic [1:0] g = grant(i);
      bit idle = m_t[i] < 0;
      bit low = m_t[i] >= ts[i] && m_t[i] < ts[i] + tl[i];
      chk($sformatf("a_ready%0d", i), a_ready[i], g[0]);
      chk($sformatf("b_ready%0d", i), b_ready[i], g[1]);
      chk($sformatf("cs%0d", i), cs[i], idle);
      chk($sformatf("wr%0d", i), wr[i], !low);
      chk($sformatf("busy%0d", i), busy[i], !idle);
      chk($sformatf("rd%0d", i), rd[i], 1);
      chk($sformatf("rs%0d", i), rs[i], m_rs[i]);
      chk($sformatf("data%0d", i), dout[i], m_d[i]);
      if (!cs[i]) cs_low[i]++;
      if (!wr[i]) wr_low[i]++;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      logic [1:0] g = grant(i);
      if (!rst) begin
        m_t[i] = -1; m_lb[i] = 1'b1; m_rs[i] = 1'b0; m_d[i] = '0;
      end else if (m_t[i] < 0) begin
        if (g != 2'b00) begin
          m_t[i] = 0; m_lb[i] = g[1];
          m_rs[i] = g[1] ? b_rs : a_rs;
          m_d[i] = g[1] ? b_data : a_data;
        end
      end else begin
        m_t[i]++;
        if (m_t[i] == ts[i] + tl[i] + th[i]) m_t[i] = -1;
      end
    end
    #1;
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1'b0; a_valid = 0; b_valid = 0; a_rs = 0; b_rs = 0; a_data = '0; b_data = '0;
    model_reset();
    @(posedge clk); #1;
    ticks(2);
    rst = 1'b1;
    ticks(2);
    // single A word
    cs_low = '{0, 0}; wr_low = '{0, 0};
    a_valid = 1; a_rs = 1; a_data = 24'hABCDEF;
    tick();
    a_valid = 0; a_data = 24'h0;
    ticks(12);
    chk("cs_low_cycles0", cs_low[0], 8);
    chk("wr_low_cycles0", wr_low[0], 3);
    chk("cs_low_cycles1", cs_low[1], 3);
    chk("wr_low_cycles1", wr_low[1], 1);
    // both requesting continuously
    for (int k = 0; k < 40; k++) begin
      a_valid = 1; b_valid = 1; a_rs = 1; b_rs = 0;
      a_data = 24'hA00000 + 24'(k); b_data = 24'hB00000 + 24'(k);
      tick();
    end
    a_valid = 0; b_valid = 0;
    ticks(10);
    // B only, then A joins
    b_valid = 1; b_data = 24'h0B0B0B; b_rs = 1;
    ticks(27);
    a_valid = 1; a_data = 24'h0A0A0A; a_rs = 0;
    ticks(20);
    // reset in the second STROBE cycle of the default instance
    for (int k = 0; k < 30 && m_t[0] != ts[0] + 1; k++) tick();
    chk("reach_strobe2", m_t[0], ts[0] + 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ticks(12);
    a_valid = 0; b_valid = 0;
    ticks(10);
    // data change during STROBE must not disturb the bus
    a_valid = 1; a_rs = 0; a_data = 24'h123456;
    tick();
    a_valid = 0;
    ticks(3);
    a_data = 24'h654321; a_rs = 1;
    ticks(8);
    chk("held_data0", dout[0], 24'h123456);
    a_valid = 1;
    ticks(10);
    // random traffic with occasional resets
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom % 64) != 0;
      a_valid = $urandom % 2; b_valid = $urandom % 2;
      a_rs = $urandom % 2; b_rs = $urandom % 2;
      a_data = 24'($urandom); b_data = 24'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
